// File: rtl/fdct2d_quant.sv
// fdct2d_quant: forward 8x8 2D DCT (row then column pass on one MAC) with reciprocal quantizer
module fdct2d_quant #(
   parameter int CW = 14,
   parameter int QW = 16
) (
   input  logic        clk,
   input  logic        reset,
   output logic        rdy,
   input  logic        en,
   input  logic [5:0]  iaddr,
   input  logic [7:0]  idata,
   input  logic        iwren,
   output logic [5:0]  maddr,
   input  logic [15:0] mq,
   output logic [5:0]  oaddr,
   output logic [15:0] odata,
   output logic        owren
);
   typedef enum logic [1:0] {IDLE, ROW, COL, OUT} state_t;
   // cos(m*pi/16) for m=0..8 in Q16, rounded down to Q1.CW/2 in cosv
   localparam logic [16:0] TCOS [9] = '{17'd65536, 17'd64277, 17'd60547, 17'd54491, 17'd46341,
                                        17'd36410, 17'd25080, 17'd12785, 17'd0};
   state_t state;
   logic [2:0] blk, k;
   logic [3:0] n;
   logic signed [31:0] acc, prod, sh;
   logic signed [15:0] a [64];
   logic signed [15:0] b [64];
   logic signed [15:0] x, wb, av;
   logic [16:0] mag;
   logic [15:0] qm, qv, odata_q;

   // k=0 uses cos(pi/4), which equals the c(0)=1/sqrt2 scaling
   function automatic logic signed [15:0] cosv(input logic [2:0] kk, input logic [2:0] nn);
      logic [4:0] m, r;
      logic [3:0] idx;
      logic [15:0] t;
      m = (kk == 3'd0) ? 5'd4 : 5'({2'b0, nn, 1'b1} * {3'b0, kk});
      r = (m > 5'd16) ? 5'd0 - m : m;
      idx = (r > 5'd8) ? 4'(5'd16 - r) : r[3:0];
      t = 16'(({1'b0, TCOS[idx]} + (18'd1 << (16 - CW))) >> (17 - CW));
      return (r > 5'd8) ? -t : t;
   endfunction

   // MAC operand, rounded/saturated writeback value and quantizer datapath
   always_comb begin
      x = (state == ROW) ? a[{blk, n[2:0]}] : b[{n[2:0], blk}];
      prod = 32'(x) * 32'(cosv(k, n[2:0]));
      sh = (acc + (32'sd1 <<< (CW - 1))) >>> CW;
      wb = (sh > 32'sd32767) ? 16'sh7fff : (sh < -32'sd32768) ? 16'sh8000 : sh[15:0];
      av = a[oaddr];
      mag = av[15] ? 17'(-{av[15], av}) : {1'b0, av};
      qm = 16'(({17'd0, mag} * {18'd0, mq} + (34'd1 << (QW - 1))) >> QW);
      qv = av[15] ? -qm : qm;
   end

   assign rdy = state == IDLE;
   assign odata = owren ? qv : odata_q;

   // sequencer: 9 cycles per coefficient over both passes, then a primed 64-cycle output burst
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         blk <= '0;
         k <= '0;
         n <= '0;
         acc <= '0;
         maddr <= '0;
         oaddr <= '0;
         owren <= 1'b0;
         odata_q <= '0;
      end else begin
         if (owren) odata_q <= qv;
         case (state)
            IDLE: if (en) state <= ROW;
            ROW, COL: begin
               acc <= (n == 4'd0) ? prod : acc + prod;
               n <= n[3] ? 4'd0 : n + 4'd1;
               if (n[3]) begin
                  k <= k + 3'd1;
                  if (k == 3'd7) blk <= blk + 3'd1;
                  if (k == 3'd7 && blk == 3'd7) begin
                     state <= (state == ROW) ? COL : OUT;
                     maddr <= '0;
                  end
               end
            end
            OUT: begin
               owren <= !(owren && oaddr == 6'd63);
               oaddr <= owren ? oaddr + 6'd1 : 6'd0;
               maddr <= maddr + 6'd1;
               if (owren && oaddr == 6'd63) state <= IDLE;
            end
         endcase
      end
   end

   // A: level-shifted pixels in IDLE, column-pass results in COL
   always_ff @(posedge clk) begin
      if (!reset && state == IDLE && iwren) a[iaddr] <= {{8{~idata[7]}}, ~idata[7], idata[6:0]};
      else if (!reset && state == COL && n[3]) a[{k, blk}] <= wb;
   end

   // B: row-pass results
   always_ff @(posedge clk) begin
      if (!reset && state == ROW && n[3]) b[{blk, k}] <= wb;
   end
endmodule

// File: tb/tb_fdct2d_quant.sv
// tb_fdct2d_quant: directed runs against a floating-point-ROM reference model via a scoreboard
module tb_fdct2d_quant;
   logic clk = 1'b0, reset = 1'b1, en = 1'b0, iwren = 1'b0;
   logic rdy, owren;
   logic [5:0] iaddr = '0, maddr, oaddr;
   logic [7:0] idata = '0;
   logic [15:0] mq = '0, odata;
   int passed = 0, fails = 0, total = 0, strobes = 0;
   int pix [64];
   int qmat [64];
   longint ct [8][8];
   typedef struct {logic [5:0] a; logic [15:0] d;} exp_t;
   exp_t sb [$];

   fdct2d_quant dut (.clk(clk), .reset(reset), .rdy(rdy), .en(en), .iaddr(iaddr), .idata(idata),
                     .iwren(iwren), .maddr(maddr), .mq(mq), .oaddr(oaddr), .odata(odata), .owren(owren));

   always #5 clk = ~clk;

   // quant-matrix RAM with one cycle of read latency
   always @(posedge clk) mq <= 16'(qmat[maddr]);

   task automatic chk(input string tag, input longint obs, input longint exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // pop and compare every coefficient strobe
   always @(negedge clk) begin
      if (owren) begin
         exp_t e;
         strobes++;
         if (sb.size() == 0) chk("spurious_owren", owren, 0);
         else begin
            e = sb.pop_front();
            chk("oaddr", oaddr, e.a);
            chk("odata", odata, e.d);
         end
      end
   end

   function automatic longint sat(input longint v);
      longint s = (v + 8192) >>> 14;
      return s > 32767 ? 32767 : s < -32768 ? -32768 : s;
   endfunction

   task automatic push_expected();
      longint s [64], t [64], u [64], acc, m, q;
      exp_t e;
      for (int i = 0; i < 64; i++) s[i] = pix[i] - 128;
      for (int r = 0; r < 8; r++)
         for (int kk = 0; kk < 8; kk++) begin
            acc = 0;
            for (int nn = 0; nn < 8; nn++) acc += s[r*8+nn] * ct[kk][nn];
            t[r*8+kk] = sat(acc);
         end
      for (int c = 0; c < 8; c++)
         for (int kk = 0; kk < 8; kk++) begin
            acc = 0;
            for (int nn = 0; nn < 8; nn++) acc += t[nn*8+c] * ct[kk][nn];
            u[kk*8+c] = sat(acc);
         end
      for (int i = 0; i < 64; i++) begin
         m = u[i] < 0 ? -u[i] : u[i];
         q = (m * qmat[i] + 32768) >>> 16;
         e.a = 6'(i);
         e.d = 16'(u[i] < 0 ? -q : q);
         sb.push_back(e);
      end
   endtask

   task automatic load(input bit en_last);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         iaddr = 6'(i);
         idata = 8'(pix[i]);
         iwren = 1'b1;
         en = en_last && i == 63;
      end
      if (!en_last) begin
         @(negedge clk);
         iwren = 1'b0;
         en = 1'b1;
      end
   endtask

   task automatic run(input bit en_last, input bit poke);
      int cyc = 0;
      strobes = 0;
      load(en_last);
      push_expected();
      @(negedge clk);
      iwren = 1'b0;
      en = 1'b0;
      chk("rdy_busy", rdy, 0);
      while (!rdy && cyc < 1400) begin
         @(posedge clk);
         cyc++;
         #1;
         en = 1'b0;
         iwren = 1'b0;
         if (poke && (cyc == 100 || cyc == 700 || cyc == 1200)) begin
            en = 1'b1;
            iwren = 1'b1;
            iaddr = 6'(cyc % 64);
            idata = 8'h5a;
         end
      end
      chk("rdy_delay", cyc, 1217);
      repeat (20) @(negedge clk);
      chk("strobes", strobes, 64);
      chk("sb_drained", sb.size(), 0);
      chk("rdy_idle", rdy, 1);
      sb.delete();
   endtask

   initial begin
      real ck;
      for (int kk = 0; kk < 8; kk++)
         for (int nn = 0; nn < 8; nn++) begin
            ck = (kk == 0) ? 0.7071067811865476 : 1.0;
            ct[kk][nn] = $rtoi($floor(16384.0 * ck / 2.0 * $cos((2*nn+1)*kk*3.141592653589793/16.0) + 0.5));
         end
      foreach (qmat[i]) qmat[i] = 0;
      repeat (2) @(negedge clk);
      chk("rst_rdy", rdy, 1);
      chk("rst_owren", owren, 0);
      chk("rst_oaddr", oaddr, 0);
      chk("rst_maddr", maddr, 0);
      chk("rst_odata", odata, 0);
      reset = 1'b0;
      foreach (pix[i]) begin pix[i] = 255; qmat[i] = 65535; end
      run(1'b0, 1'b0);
      foreach (pix[i]) begin pix[i] = 128; qmat[i] = int'($urandom_range(65535, 1)); end
      run(1'b0, 1'b0);
      foreach (pix[i]) begin pix[i] = 0; qmat[i] = 4096; end
      run(1'b0, 1'b0);
      foreach (pix[i]) begin pix[i] = i * 4; qmat[i] = 65535; end
      run(1'b0, 1'b0);
      run(1'b1, 1'b0);
      foreach (pix[i]) begin pix[i] = int'($urandom_range(255)); qmat[i] = int'($urandom_range(65535, 1)); end
      run(1'b0, 1'b1);
      strobes = 0;
      load(1'b0);
      @(negedge clk);
      iwren = 1'b0;
      en = 1'b0;
      repeat (800) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_col_rdy", rdy, 1);
      chk("rst_col_owren", owren, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (1300) @(negedge clk);
      chk("rst_col_strobes", strobes, 0);
      chk("rst_col_idle", rdy, 1);
      foreach (pix[i]) begin pix[i] = 255 - i * 3; qmat[i] = int'($urandom_range(65535, 1)); end
      run(1'b0, 1'b0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
